// File: rtl/serial_word_collector.sv
// Serial-to-parallel collector: packs qualified serial bits LSB-first into WIDTH-bit
// words and hands them out over valid/ready, flagging words dropped under back-pressure.
module serial_word_collector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] word;
    logic             complete;

    // New bits enter at the MSB so the first bit of a word ends up at bit 0.
    assign word     = {bit_in, shift[WIDTH-1:1]};
    assign complete = bit_valid && !clr && (bit_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= EMPTY;
            shift      <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (clr) begin
                shift    <= '0;
                bit_cnt  <= '0;
                overflow <= 1'b0;
            end else if (bit_valid) begin
                shift   <= word;
                bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
            end

            // The handshake keeps running on clr edges; clr only suppresses completion.
            case (state)
                EMPTY: begin
                    if (complete) begin
                        data_out   <= word;
                        data_valid <= 1'b1;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (data_ready) begin
                        if (complete) begin
                            data_out <= word;
                        end else begin
                            data_valid <= 1'b0;
                            state      <= EMPTY;
                        end
                    end else if (complete) begin
                        overflow <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector: directed scenarios plus a randomized
// run compared against a queue-based model of the collecting and handshake rules.
module tb_serial_word_collector;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n, bit_in, bit_valid, clr, data_ready;
    logic [W-1:0]  data_out;
    logic          data_valid, overflow;
    logic [CW-1:0] bit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit           m_q[$];
    logic         m_valid;
    logic [W-1:0] m_dout;
    logic         m_ovf;

    serial_word_collector #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .clr(clr), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .overflow(overflow), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // Apply inputs for one rising edge, advance the model, return at the falling edge.
    task automatic cyc(input logic r, input logic bv, input logic bi, input logic c, input logic rd);
        logic         comp;
        logic [W-1:0] wd;
        reset_n = r; bit_valid = bv; bit_in = bi; clr = c; data_ready = rd;
        @(posedge clk);
        comp = 1'b0;
        wd   = '0;
        if (!r) begin
            m_q.delete();
            m_valid = 1'b0; m_dout = '0; m_ovf = 1'b0;
        end else begin
            if (c) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else if (bv) begin
                m_q.push_back(bi);
                if (m_q.size() == W) begin
                    for (int i = 0; i < W; i++) wd[i] = m_q[i];
                    comp = 1'b1;
                    m_q.delete();
                end
            end
            if (m_valid && rd) m_valid = 1'b0;
            if (comp) begin
                if (!m_valid) begin
                    m_valid = 1'b1;
                    m_dout  = wd;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [W-1:0] pat;
        pat = 8'h4D;
        do_reset();
        n_checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b0 || overflow !== 1'b0 || bit_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got dout=%h v=%b ovf=%b cnt=%0d expected 00 0 0 0",
                     data_out, data_valid, overflow, bit_cnt);
        end
        for (int i = 0; i < W; i++) begin
            cyc(1'b1, 1'b1, pat[i], 1'b0, 1'b0);
            if (i == W - 2) begin
                n_checks++;
                if (data_valid !== 1'b0 || bit_cnt !== 3'd7) begin
                    n_fail++;
                    $display("FAIL reset_pre_complete: got v=%b cnt=%0d expected 0 7", data_valid, bit_cnt);
                end
            end
        end
        n_checks++;
        if (data_out !== 8'h4D || data_valid !== 1'b1 || bit_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_first_word: got dout=%h v=%b cnt=%0d expected 4d 1 0",
                     data_out, data_valid, bit_cnt);
        end
    endtask

    task automatic test_gapped();
        logic [W-1:0] pat;
        pat = 8'h4D;
        do_reset();
        for (int i = 0; i < W; i++) begin
            cyc(1'b1, 1'b1, pat[i], 1'b0, 1'b0);
            cyc(1'b1, 1'b0, ~pat[i], 1'b0, 1'b0);
            if (i < W - 1) begin
                n_checks++;
                if (bit_cnt !== CW'(i + 1) || data_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gapped_hold: got cnt=%0d v=%b expected %0d 0", bit_cnt, data_valid, i + 1);
                end
            end
        end
        n_checks++;
        if (data_out !== 8'h4D || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gapped_word: got dout=%h v=%b expected 4d 1", data_out, data_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] s;
        s = {8'h3C, 8'hA5};
        do_reset();
        for (int i = 0; i < 2 * W; i++) begin
            cyc(1'b1, 1'b1, s[i], 1'b0, (i == 2 * W - 1));
            if (i == 2 * W - 2) begin
                n_checks++;
                if (data_out !== 8'hA5 || data_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_first: got dout=%h v=%b expected a5 1", data_out, data_valid);
                end
            end
        end
        n_checks++;
        if (data_out !== 8'h3C || data_valid !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got dout=%h v=%b ovf=%b expected 3c 1 0", data_out, data_valid, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [2*W-1:0] s;
        s = {8'h3C, 8'hA5};
        do_reset();
        for (int i = 0; i < 2 * W; i++) cyc(1'b1, 1'b1, s[i], 1'b0, 1'b0);
        n_checks++;
        if (data_out !== 8'hA5 || data_valid !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: got dout=%h v=%b ovf=%b expected a5 1 1", data_out, data_valid, overflow);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (data_valid !== 1'b0 || overflow !== 1'b1 || data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL ovf_sticky: got v=%b ovf=%b dout=%h expected 0 1 a5", data_valid, overflow, data_out);
        end
    endtask

    // Runs straight after test_overflow so the clr has a set overflow to clear.
    task automatic test_clr();
        logic [W-1:0] pat;
        pat = 8'hF0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bit_cnt !== 3'd0 || overflow !== 1'b0 || data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL clr_edge: got cnt=%0d ovf=%b dout=%h expected 0 0 a5", bit_cnt, overflow, data_out);
        end
        for (int i = 0; i < W; i++) cyc(1'b1, 1'b1, pat[i], 1'b0, 1'b0);
        n_checks++;
        if (data_out !== 8'hF0 || data_valid !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_word: got dout=%h v=%b ovf=%b expected f0 1 0", data_out, data_valid, overflow);
        end
    endtask

    task automatic test_reset_midword();
        logic [W-1:0] pat;
        pat = 8'h96;
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, pat[i], 1'b0, 1'b0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        n_checks++;
        if (bit_cnt !== 3'd5) begin
            n_fail++;
            $display("FAIL glitch_cnt: got cnt=%0d expected 5", bit_cnt);
        end
        for (int i = 5; i < W; i++) cyc(1'b1, 1'b1, pat[i], 1'b0, 1'b0);
        n_checks++;
        if (data_out !== 8'h96 || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_word: got dout=%h v=%b expected 96 1", data_out, data_valid);
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bit_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL midword_cnt: got cnt=%0d expected 4", bit_cnt);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bit_cnt !== 3'd0 || data_valid !== 1'b0 || data_out !== 8'h00 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midword_reset: got cnt=%0d v=%b dout=%h ovf=%b expected 0 0 00 0",
                     bit_cnt, data_valid, data_out, overflow);
        end
    endtask

    task automatic test_random();
        logic r, bv, bi, c, rd;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 299) != 0);
            bv = ($urandom_range(0, 3) != 0);
            bi = 1'($urandom);
            c  = ($urandom_range(0, 47) == 0);
            rd = ($urandom_range(0, 9) < 3);
            cyc(r, bv, bi, c, rd);
            n_checks++;
            if (data_out !== m_dout || data_valid !== m_valid || overflow !== m_ovf
                || bit_cnt !== CW'(m_q.size())) begin
                n_fail++;
                $display("FAIL random[%0d]: got dout=%h v=%b ovf=%b cnt=%0d expected %h %b %b %0d",
                         n, data_out, data_valid, overflow, bit_cnt, m_dout, m_valid, m_ovf, m_q.size());
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr = 1'b0; data_ready = 1'b0;
        m_valid = 1'b0; m_dout = '0; m_ovf = 1'b0;
        @(negedge clk);
        test_reset();
        test_gapped();
        test_back_to_back();
        test_overflow();
        test_clr();
        test_reset_midword();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
